// File: rtl/ctrl_sequencer.sv
// rtl/ctrl_sequencer.sv - hardwired fetch/decode/execute strobe sequencer for the Datapath
module ctrl_sequencer #(
    parameter logic [4:0] OP_LD    = 5'b00000,
    parameter logic [4:0] OP_LDI   = 5'b00001,
    parameter logic [4:0] OP_ST    = 5'b00010,
    parameter logic [4:0] OP_ADDI  = 5'b01100,
    parameter logic [4:0] OP_ANDI  = 5'b01101,
    parameter logic [4:0] OP_ORI   = 5'b01110,
    parameter logic [4:0] ALU_ADD  = 5'b00011,
    parameter logic [4:0] ALU_AND  = 5'b00101,
    parameter logic [4:0] ALU_OR   = 5'b00110,
    parameter bit         RUN_CONT = 1'b0,
    parameter int         TMO      = 15,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             halt,
    input  logic             mem_ready,
    input  logic [4:0]       ir_op,
    output logic             PC_out,
    output logic             MARin,
    output logic             IncPC,
    output logic             Zlowin,
    output logic             Zlo_out,
    output logic             PCin,
    output logic             Read,
    output logic             Write,
    output logic             MDRin,
    output logic             MDR_out,
    output logic             IRin,
    output logic             Gra,
    output logic             Grb,
    output logic             BAout,
    output logic             R_out,
    output logic             Rin,
    output logic             Yin,
    output logic             C_out,
    output logic [4:0]       op_sel,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_ERR
    } state_t;

    localparam logic [7:0] TMO_C = 8'(TMO);

    state_t     state;
    logic [7:0] wait_cnt;   // consecutive mem_ready-low cycles in the current memory state
    logic       pc_done;    // PCin already pulsed during this T1 visit
    logic       is_ld, is_st, is_imm, legal;
    logic       in_mem, retire;
    state_t     after_retire;

    // Opcode classification and memory-wait / retire conditions
    always_comb begin
        is_ld        = (ir_op == OP_LD);
        is_st        = (ir_op == OP_ST);
        is_imm       = (ir_op == OP_LDI) || (ir_op == OP_ADDI) ||
                       (ir_op == OP_ANDI) || (ir_op == OP_ORI);
        legal        = is_ld || is_st || is_imm;
        in_mem       = (state == S_T1) || (state == S_T6 && is_ld) || (state == S_T7 && is_st);
        retire       = ((state == S_T5) && is_imm) ||
                       ((state == S_T7) && (is_ld || (is_st && mem_ready)));
        after_retire = (RUN_CONT && !halt) ? S_T0 : S_IDLE;
    end

    // State, wait counter and retired-instruction counter
    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= S_IDLE;
            wait_cnt  <= 8'd0;
            pc_done   <= 1'b0;
            instr_cnt <= '0;
        end else begin
            pc_done  <= (state == S_T1);
            wait_cnt <= (in_mem && !mem_ready) ? wait_cnt + 8'd1 : 8'd0;
            if (retire)
                instr_cnt <= instr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (in_mem && !mem_ready && wait_cnt == TMO_C) begin
                state <= S_ERR;
            end else begin
                case (state)
                    S_IDLE: if (start) state <= S_T0;
                    S_T0:   state <= S_T1;
                    S_T1:   if (mem_ready) state <= S_T2;
                    S_T2:   state <= S_T3;
                    S_T3:   state <= legal ? S_T4 : S_ERR;
                    S_T4:   state <= S_T5;
                    S_T5:   state <= (is_ld || is_st) ? S_T6 : after_retire;
                    S_T6:   if (is_st || mem_ready) state <= S_T7;
                    S_T7:   if (retire) state <= after_retire;
                    S_ERR:  state <= S_ERR;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Strobe decode; combinational because ir_op only becomes valid once T3 is entered
    always_comb begin
        {PC_out, MARin, IncPC, Zlowin, Zlo_out, PCin, Read, Write, MDRin} = '0;
        {MDR_out, IRin, Gra, Grb, BAout, R_out, Rin, Yin, C_out}         = '0;
        op_sel = 5'd0;
        case (state)
            S_T0: begin PC_out = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1; end
            S_T1: begin Zlo_out = 1'b1; PCin = !pc_done; Read = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDR_out = 1'b1; IRin = 1'b1; end
            S_T3: begin
                Grb = 1'b1; R_out = 1'b1; Yin = 1'b1;
                BAout = is_ld || is_st || (ir_op == OP_LDI);
            end
            S_T4: begin
                C_out = 1'b1; Zlowin = 1'b1;
                if (ir_op == OP_ANDI)     op_sel = ALU_AND;
                else if (ir_op == OP_ORI) op_sel = ALU_OR;
                else                      op_sel = ALU_ADD;
            end
            S_T5: begin
                Zlo_out = 1'b1;
                if (is_ld || is_st) MARin = 1'b1;
                else begin Gra = 1'b1; Rin = 1'b1; end
            end
            S_T6: begin
                if (is_ld)      begin Read = 1'b1; MDRin = 1'b1; end
                else if (is_st) begin Gra = 1'b1; R_out = 1'b1; MDRin = 1'b1; end
            end
            S_T7: begin
                if (is_ld)      begin MDR_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                else if (is_st) Write = 1'b1;
            end
            default: ;
        endcase
        done = retire;
        busy = (state != S_IDLE) && (state != S_ERR);
        err  = (state == S_ERR);
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb/tb_ctrl_sequencer.sv - randomized trace-model bench for ctrl_sequencer
module tb_ctrl_sequencer;

    localparam logic [4:0] OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010;
    localparam logic [4:0] OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI = 5'b01110;
    localparam logic [4:0] ALU_ADD = 5'b00011, ALU_AND = 5'b00101, ALU_OR = 5'b00110;

    localparam logic [17:0] M_PC_OUT = 18'h20000, M_MARIN = 18'h10000, M_INCPC = 18'h08000;
    localparam logic [17:0] M_ZLOWIN = 18'h04000, M_ZLO_OUT = 18'h02000, M_PCIN = 18'h01000;
    localparam logic [17:0] M_READ = 18'h00800, M_WRITE = 18'h00400, M_MDRIN = 18'h00200;
    localparam logic [17:0] M_MDR_OUT = 18'h00100, M_IRIN = 18'h00080, M_GRA = 18'h00040;
    localparam logic [17:0] M_GRB = 18'h00020, M_BAOUT = 18'h00010, M_R_OUT = 18'h00008;
    localparam logic [17:0] M_RIN = 18'h00004, M_YIN = 18'h00002, M_C_OUT = 18'h00001;

    logic clk = 1'b0;
    logic clr, start, start_c, halt, mem_ready;
    logic [4:0] ir_op;
    logic [17:0] s0, s1;
    logic [4:0] op0, op1;
    logic busy0, done0, err0, busy1, done1, err1;
    logic [15:0] cnt0, cnt1;
    logic [25:0] v0, v1;

    assign v0 = {s0, op0, busy0, done0, err0};
    assign v1 = {s1, op1, busy1, done1, err1};

    always #5 clk = ~clk;

    ctrl_sequencer #(.RUN_CONT(1'b0)) u_dut (
        .clk(clk), .clr(clr), .start(start), .halt(halt), .mem_ready(mem_ready), .ir_op(ir_op),
        .PC_out(s0[17]), .MARin(s0[16]), .IncPC(s0[15]), .Zlowin(s0[14]), .Zlo_out(s0[13]),
        .PCin(s0[12]), .Read(s0[11]), .Write(s0[10]), .MDRin(s0[9]), .MDR_out(s0[8]),
        .IRin(s0[7]), .Gra(s0[6]), .Grb(s0[5]), .BAout(s0[4]), .R_out(s0[3]), .Rin(s0[2]),
        .Yin(s0[1]), .C_out(s0[0]), .op_sel(op0), .busy(busy0), .done(done0), .err(err0),
        .instr_cnt(cnt0)
    );

    ctrl_sequencer #(.RUN_CONT(1'b1)) u_cont (
        .clk(clk), .clr(clr), .start(start_c), .halt(halt), .mem_ready(mem_ready), .ir_op(ir_op),
        .PC_out(s1[17]), .MARin(s1[16]), .IncPC(s1[15]), .Zlowin(s1[14]), .Zlo_out(s1[13]),
        .PCin(s1[12]), .Read(s1[11]), .Write(s1[10]), .MDRin(s1[9]), .MDR_out(s1[8]),
        .IRin(s1[7]), .Gra(s1[6]), .Grb(s1[5]), .BAout(s1[4]), .R_out(s1[3]), .Rin(s1[2]),
        .Yin(s1[1]), .C_out(s1[0]), .op_sel(op1), .busy(busy1), .done(done1), .err(err1),
        .instr_cnt(cnt1)
    );

    // One expected cycle: outputs plus the inputs driven during that cycle
    typedef struct {
        logic [25:0] exp;
        logic        mr, st, h, c;
    } cyc_t;

    cyc_t tr[$];
    int   pass_cnt = 0, tot_cnt = 0, fail_cnt = 0;
    int   exp_cnt0 = 0;
    logic [4:0] ops [6] = '{OP_LD, OP_LDI, OP_ST, OP_ADDI, OP_ANDI, OP_ORI};

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        tot_cnt++;
        assert (o === e) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic add(input logic [17:0] sb, input logic [4:0] os, input logic bz,
                       input logic dn, input logic er, input logic mr);
        cyc_t r;
        r.exp = {sb, os, bz, dn, er};
        r.mr  = mr;
        r.st  = 1'($urandom_range(0, 1));
        r.h   = 1'($urandom_range(0, 1));
        r.c   = 1'b0;
        tr.push_back(r);
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected trace of one instruction: w1 wait cycles in fetch, wm in the data memory phase
    task automatic build(input logic [4:0] op, input int w1, input int wm);
        logic is_ld, is_st, is_imm, ba;
        logic [4:0] alu;
        is_ld  = (op == OP_LD);
        is_st  = (op == OP_ST);
        is_imm = (op == OP_LDI) || (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
        ba     = is_ld || is_st || (op == OP_LDI);
        alu    = (op == OP_ANDI) ? ALU_AND : (op == OP_ORI) ? ALU_OR : ALU_ADD;
        add(M_PC_OUT | M_MARIN | M_INCPC | M_ZLOWIN, 5'd0, 1, 0, 0, rnd());
        for (int i = 0; i <= w1; i++)
            add(M_ZLO_OUT | M_READ | M_MDRIN | ((i == 0) ? M_PCIN : 18'd0), 5'd0, 1, 0, 0, i == w1);
        add(M_MDR_OUT | M_IRIN, 5'd0, 1, 0, 0, rnd());
        add(M_GRB | M_R_OUT | M_YIN | (ba ? M_BAOUT : 18'd0), 5'd0, 1, 0, 0, rnd());
        if (is_imm || is_ld || is_st)
            add(M_C_OUT | M_ZLOWIN, alu, 1, 0, 0, rnd());
        if (is_imm)
            add(M_ZLO_OUT | M_GRA | M_RIN, 5'd0, 1, 1, 0, rnd());
        if (is_ld || is_st)
            add(M_ZLO_OUT | M_MARIN, 5'd0, 1, 0, 0, rnd());
        if (is_ld) begin
            for (int i = 0; i <= wm; i++)
                add(M_READ | M_MDRIN, 5'd0, 1, 0, 0, i == wm);
            add(M_MDR_OUT | M_GRA | M_RIN, 5'd0, 1, 1, 0, rnd());
        end
        if (is_st) begin
            add(M_GRA | M_R_OUT | M_MDRIN, 5'd0, 1, 0, 0, rnd());
            for (int i = 0; i <= wm; i++)
                add(M_WRITE, 5'd0, 1, i == wm, 0, i == wm);
        end
    endtask

    task automatic add_err(input int n, input logic c_last);
        for (int i = 0; i < n; i++) begin
            add(18'd0, 5'd0, 0, 0, 1, rnd());
            tr[tr.size()-1].st = 1'b1;
            tr[tr.size()-1].c  = c_last && (i == n - 1);
        end
    endtask

    task automatic go(input bit which);
        @(negedge clk);
        if (which) start_c = 1'b1; else start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        start_c = 1'b0;
    endtask

    task automatic play(input bit which, input string tag);
        foreach (tr[k]) begin
            mem_ready = tr[k].mr;
            clr       = tr[k].c;
            halt      = tr[k].h;
            start     = which ? 1'b0 : tr[k].st;
            #1;
            chk($sformatf("%s_cyc%0d", tag, k), which ? 64'(v1) : 64'(v0), 64'(tr[k].exp));
            @(negedge clk);
        end
        start = 1'b0;
        clr   = 1'b0;
        halt  = 1'b0;
    endtask

    task automatic check_idle(input bit which, input string tag, input int ecnt);
        #1;
        chk({tag, "_idle"}, which ? 64'(v1) : 64'(v0), 64'd0);
        chk({tag, "_cnt"}, which ? 64'(cnt1) : 64'(cnt0), 64'(ecnt));
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; start_c = 1'b0; halt = 1'b0; mem_ready = 1'b1; ir_op = OP_LDI;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        check_idle(0, "reset_dut", 0);
        check_idle(1, "reset_cont", 0);

        // clr in the middle of T4 aborts the instruction
        ir_op = OP_LDI;
        tr.delete(); build(OP_LDI, 0, 0);
        while (tr.size() > 5) void'(tr.pop_back());
        tr[4].c = 1'b1;
        go(0); play(0, "clr_t4");
        check_idle(0, "clr_t4", 0);

        // ldi, no waits
        tr.delete(); build(OP_LDI, 0, 0);
        go(0); play(0, "ldi"); exp_cnt0++;
        check_idle(0, "ldi", exp_cnt0);

        // ld with 3 fetch waits and 2 data waits
        ir_op = OP_LD;
        tr.delete(); build(OP_LD, 3, 2);
        go(0); play(0, "ld_wait"); exp_cnt0++;
        check_idle(0, "ld_wait", exp_cnt0);

        // st, no waits
        ir_op = OP_ST;
        tr.delete(); build(OP_ST, 0, 0);
        go(0); play(0, "st"); exp_cnt0++;
        check_idle(0, "st", exp_cnt0);

        // illegal opcode: ERR after T3, start ignored, clr exits
        ir_op = 5'b11111;
        tr.delete(); build(5'b11111, 1, 0);
        add_err(11, 1'b1);
        go(0); play(0, "illegal"); exp_cnt0 = 0;
        check_idle(0, "illegal", 0);

        // fetch timeout: 16 consecutive low cycles in T1 then ERR
        ir_op = OP_LD;
        tr.delete();
        add(M_PC_OUT | M_MARIN | M_INCPC | M_ZLOWIN, 5'd0, 1, 0, 0, 1'b0);
        for (int i = 0; i < 16; i++)
            add(M_ZLO_OUT | M_READ | M_MDRIN | ((i == 0) ? M_PCIN : 18'd0), 5'd0, 1, 0, 0, 1'b0);
        add_err(3, 1'b1);
        go(0); play(0, "tmo");
        check_idle(0, "tmo", 0);

        // continuous mode: three andi back to back, halt raised during the third
        ir_op = OP_ANDI;
        tr.delete();
        for (int n = 0; n < 3; n++) begin
            int base;
            base = tr.size();
            build(OP_ANDI, $urandom_range(0, 2), 0);
            for (int k = base; k < tr.size(); k++) tr[k].h = (n == 2);
        end
        go(1); play(1, "cont_andi");
        check_idle(1, "cont_andi", 3);

        // randomized instruction mix with random wait states
        for (int n = 0; n < 30; n++) begin
            logic [4:0] op;
            op = ops[$urandom_range(0, 5)];
            ir_op = op;
            tr.delete(); build(op, $urandom_range(0, 3), $urandom_range(0, 3));
            go(0); play(0, $sformatf("rnd%0d_op%0h", n, op)); exp_cnt0++;
            check_idle(0, $sformatf("rnd%0d", n), exp_cnt0);
        end

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
